// File: rtl/bram_uart_tx_if.sv
// BRAM read port seen by the UART transmitter: one-cycle read latency,
// the transmitter is the master issuing enable/address.
interface bram_uart_tx_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  o_rd_en;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic [DATA_WIDTH-1:0] i_rd_data;

  modport master (output o_rd_en, output o_rd_addr, input i_rd_data);
  modport slave  (input o_rd_en, input o_rd_addr, output i_rd_data);
endinterface

// File: rtl/bram_uart_tx.sv
// 8N1 UART transmitter that drains N_WORDS BRAM words, LSB byte and LSB bit
// first, with bit timing driven by a shared oversample tick enable.
module bram_uart_tx #(
  parameter int OVERSAMPLE  = 13,
  parameter int N_DATA_BITS = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int N_WORDS     = 16,
  parameter int WORD_BYTES  = 2
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_en,
  input  logic           i_start,
  bram_uart_tx_if.master bram,
  output logic           o_tx,
  output logic           o_busy,
  output logic           o_done
);

  localparam int WORD_W = WORD_BYTES * N_DATA_BITS;
  localparam int TW     = (OVERSAMPLE  > 1) ? $clog2(OVERSAMPLE)  : 1;
  localparam int BW     = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;
  localparam int YW     = (WORD_BYTES  > 1) ? $clog2(WORD_BYTES)  : 1;

  localparam logic [TW-1:0]         TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]         BIT_LAST  = BW'(N_DATA_BITS - 1);
  localparam logic [YW-1:0]         BYTE_LAST = YW'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_LAST = ADDR_WIDTH'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_tick;
  logic [BW-1:0]         r_bit;
  logic [YW-1:0]         r_byte;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_en;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic [WORD_W-1:0]     r_buf;

  logic w_tick_last;
  logic w_load;
  logic w_shift;

  assign w_tick_last = i_en && (r_tick == TICK_LAST);
  assign w_load      = (r_state == S_LOAD);
  assign w_shift     = (r_state == S_DATA) && w_tick_last;

  // Word buffer shifts right once per data bit, so bit 0 is always the next
  // bit to send and the following byte slides down after N_DATA_BITS shifts.
  always_ff @(posedge i_clk) begin
    if (w_load)
      r_buf <= bram.i_rd_data;
    else if (w_shift)
      r_buf <= r_buf >> 1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_word  <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: r_state <= S_LOAD;
        S_LOAD: begin
          r_byte  <= '0;
          r_tick  <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_tx    <= r_buf[0];
            r_state <= S_DATA;
          end else if (i_en) begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_tick <= '0;
            if (r_bit == BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_buf[1];
            end
          end else if (i_en) begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_state <= S_NEXT;
          end else if (i_en) begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_NEXT: begin
          if (r_byte != BYTE_LAST) begin
            r_byte  <= r_byte + 1'b1;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else if (r_word != WORD_LAST) begin
            r_word  <= r_word + 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bram.o_rd_en   = r_rd_en;
  assign bram.o_rd_addr = r_addr;
  assign o_tx           = r_tx;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_bram_uart_tx.sv
// Directed bench for bram_uart_tx: two instances (single-word fast timing and
// full 16-word transfer) observed through a serial decoder and read counters.
module tb_bram_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  int   mode = 0;
  int   ecnt = 0;
  bit   sel = 1'b0;
  int   cyc = 0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bram_uart_tx_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if_a ();
  bram_uart_tx_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if_b ();

  bram_uart_tx #(.OVERSAMPLE(4), .N_DATA_BITS(8), .ADDR_WIDTH(4), .N_WORDS(1), .WORD_BYTES(2)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_en(en), .i_start(start_a),
    .bram(if_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a));

  bram_uart_tx #(.OVERSAMPLE(13), .N_DATA_BITS(8), .ADDR_WIDTH(4), .N_WORDS(16), .WORD_BYTES(2)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_en(en), .i_start(start_b),
    .bram(if_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b));

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0100 + 16'(i);
    end
    mem_a[0] = 16'hA53C;
  end

  always @(posedge clk) begin
    if (if_a.o_rd_en) if_a.i_rd_data <= mem_a[if_a.o_rd_addr];
    if (if_b.o_rd_en) if_b.i_rd_data <= mem_b[if_b.o_rd_addr];
    cyc <= cyc + 1;
  end

  // Tick enable: 0 = every cycle, 1 = every 13th cycle, 2 = stalled low.
  initial forever begin
    @(posedge clk);
    #1;
    ecnt++;
    case (mode)
      0: en = 1'b1;
      1: en = (ecnt % 13 == 0);
      default: en = 1'b0;
    endcase
  end

  logic       w_tx_m, w_rd_en_m, w_done_m, w_busy_m;
  logic [3:0] w_addr_m;
  int         om;
  assign w_tx_m    = sel ? tx_b : tx_a;
  assign w_rd_en_m = sel ? if_b.o_rd_en : if_a.o_rd_en;
  assign w_addr_m  = sel ? if_b.o_rd_addr : if_a.o_rd_addr;
  assign w_done_m  = sel ? done_b : done_a;
  assign w_busy_m  = sel ? busy_b : busy_a;
  assign om        = sel ? 13 : 4;

  int rd_n = 0;
  int done_n = 0;
  int hits [16];
  initial for (int i = 0; i < 16; i++) hits[i] = 0;

  always @(negedge clk) begin
    if (rst_n && w_rd_en_m) begin
      rd_n <= rd_n + 1;
      hits[w_addr_m] <= hits[w_addr_m] + 1;
    end
    if (rst_n && w_done_m) done_n <= done_n + 1;
  end

  // Serial decoder: mid-bit sampling counted in enable ticks; reset drops a frame.
  logic [7:0] rx_q [$];
  int         falls [$];
  int         rx_bad = 0;
  int         m_c;
  bit         m_abort, m_start_ok, m_stop_ok;
  logic [7:0] m_b;

  initial forever begin
    @(negedge clk);
    if (rst_n && !w_tx_m) begin
      falls.push_back(cyc);
      m_c = en ? 1 : 0;
      m_abort = 1'b0;
      m_b = 8'h00;
      m_start_ok = 1'b0;
      m_stop_ok = 1'b0;
      for (int k = 0; k <= 9; k++) begin
        while (!m_abort && m_c < om / 2 + k * om) begin
          @(negedge clk);
          if (!rst_n) m_abort = 1'b1;
          else if (en) m_c++;
        end
        if (!m_abort) begin
          if (k == 0) m_start_ok = (w_tx_m == 1'b0);
          else if (k == 9) m_stop_ok = (w_tx_m == 1'b1);
          else m_b[k-1] = w_tx_m;
        end
      end
      if (!m_abort) begin
        rx_q.push_back(m_b);
        if (!(m_start_ok && m_stop_ok)) rx_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] fall_gap(input int i);
    if (i + 1 < falls.size()) return 32'(falls[i+1] - falls[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic pulse_start(input bit which);
    @(posedge clk);
    #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!w_done_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(w_done_m), 1);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n;
    n = 0;
    while (w_tx_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_fall"}, 32'(w_tx_m), 0);
  endtask

  task automatic check_seq(input string tag, input int base);
    chk({tag, "_nbytes"}, 32'(rx_q.size() - base), 32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("%s_byte%0d", tag, k), rx_at(base + k), (k % 2 == 0) ? 32'(k / 2) : 32'h01);
  endtask

  int rb, fb, db, rdb, bad, bb, v;
  int hb [16];

  initial begin
    // Reset and idle behaviour of both instances
    repeat (4) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 1);
    chk("rst_tx_b", 32'(tx_b), 1);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_done_b", 32'(done_b), 0);
    chk("rst_rden_b", 32'(if_b.o_rd_en), 0);
    chk("rst_addr_b", 32'(if_b.o_rd_addr), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!(tx_a && tx_b) || busy_a || busy_b || done_a || done_b || if_a.o_rd_en || if_b.o_rd_en) bad++;
    end
    chk("idle_1000", 32'(bad), 0);

    // Single word 16'hA53C, 4 ticks per bit, tick every cycle
    sel = 1'b0;
    mode = 0;
    rb = rx_q.size(); fb = falls.size(); db = done_n; rdb = rd_n;
    pulse_start(1'b0);
    chk("a_busy_next", 32'(busy_a), 1);
    chk("a_rden_fetch", 32'(if_a.o_rd_en), 1);
    chk("a_addr_fetch", 32'(if_a.o_rd_addr), 0);
    wait_done("a", 500);
    chk("a_busy_at_done", 32'(busy_a), 0);
    @(negedge clk);
    chk("a_done_1cyc", 32'(done_a), 0);
    chk("a_nbytes", 32'(rx_q.size() - rb), 2);
    chk("a_byte0", rx_at(rb), 32'h3C);
    chk("a_byte1", rx_at(rb + 1), 32'hA5);
    chk("a_frame_gap", fall_gap(fb), 41);
    chk("a_done_count", 32'(done_n - db), 1);
    chk("a_rd_count", 32'(rd_n - rdb), 1);
    chk("a_bad_frames", 32'(rx_bad), 0);

    // Enable stall of 50 cycles in the middle of data bit 3 of the first byte
    repeat (3) @(negedge clk);
    rb = rx_q.size(); fb = falls.size();
    pulse_start(1'b0);
    wait_tx_low("g", 20);
    repeat (17) @(negedge clk);
    chk("g_bit3_level", 32'(tx_a), 1);
    mode = 2;
    v = 32'(tx_a);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (32'(tx_a) != v) bad++;
    end
    chk("g_tx_frozen", 32'(bad), 0);
    chk("g_busy_stall", 32'(busy_a), 1);
    mode = 0;
    wait_done("g", 500);
    chk("g_byte0", rx_at(rb), 32'h3C);
    chk("g_byte1", rx_at(rb + 1), 32'hA5);
    chk("g_frame_gap", fall_gap(fb), 91);

    // Full 16-word transfer, tick every 13th cycle, start re-pulsed mid-transfer
    sel = 1'b1;
    mode = 1;
    repeat (3) @(negedge clk);
    rb = rx_q.size(); db = done_n; rdb = rd_n; bb = rx_bad;
    for (int i = 0; i < 16; i++) hb[i] = hits[i];
    pulse_start(1'b1);
    chk("b_busy_next", 32'(busy_b), 1);
    chk("b_addr_fetch", 32'(if_b.o_rd_addr), 0);
    bad = 0;
    while (rx_q.size() < rb + 1 && bad < 4000) begin
      @(negedge clk);
      bad++;
    end
    chk("b_first_byte_seen", 32'(rx_q.size() > rb), 1);
    wait_tx_low("b2", 600);
    repeat (20) @(negedge clk);
    pulse_start(1'b1);
    chk("b_busy_after_repulse", 32'(busy_b), 1);
    wait_done("b", 60000);
    chk("b_busy_at_done", 32'(busy_b), 0);
    @(negedge clk);
    chk("b_addr_wrap", 32'(if_b.o_rd_addr), 0);
    chk("b_done_1cyc", 32'(done_b), 0);
    check_seq("b", rb);
    repeat (30) @(negedge clk);
    chk("b_done_count", 32'(done_n - db), 1);
    chk("b_rd_count", 32'(rd_n - rdb), 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (hits[i] - hb[i] != 1) bad++;
    chk("b_addr_each_once", 32'(bad), 0);
    chk("b_bad_frames", 32'(rx_bad - bb), 0);
    chk("b_still_idle", 32'(busy_b), 0);

    // Asynchronous reset during data bit 5 of the first frame, then restart
    mode = 0;
    pulse_start(1'b1);
    wait_tx_low("r", 20);
    repeat (84) @(negedge clk);
    chk("r_bit5_level", 32'(tx_b), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_tx_async", 32'(tx_b), 1);
    chk("r_busy_async", 32'(busy_b), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("r_idle_tx", 32'(tx_b), 1);
    rb = rx_q.size(); db = done_n; bb = rx_bad;
    pulse_start(1'b1);
    chk("r_restart_rden", 32'(if_b.o_rd_en), 1);
    chk("r_restart_addr", 32'(if_b.o_rd_addr), 0);
    wait_done("r", 6000);
    check_seq("r", rb);
    repeat (3) @(negedge clk);
    chk("r_done_count", 32'(done_n - db), 1);
    chk("r_bad_frames", 32'(rx_bad - bb), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
